// File: rtl/connect4_pkg.sv
// Shared types for the Connect-4 game core: cell codes, FSM states and helpers.
package connect4_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P0    = 2'b01,
        P1    = 2'b10
    } cell_t;

    typedef enum logic [2:0] {
        StWait,
        StDrop,
        StChkH,
        StChkV,
        StChkD1,
        StChkD2,
        StSwap,
        StDone
    } state_t;

    localparam logic [1:0] WIN_DRAW = 2'b11;

    function automatic cell_t player_code(input logic player);
        return player ? P1 : P0;
    endfunction

endpackage

// File: rtl/connect4_board_ctrl_if.sv
// Move input and board/status output bundle between the input front-end and the game core.
interface connect4_board_ctrl_if #(
    parameter int unsigned ROWS      = 6,
    parameter int unsigned COLS      = 7,
    parameter int unsigned TURN_SECS = 10
);
    logic [$clog2(COLS)-1:0]        column;
    logic                           load;
    logic                           first_player;
    logic [2*ROWS*COLS-1:0]         board;
    logic                           cur_player;
    logic [$clog2(TURN_SECS+1)-1:0] secs;
    logic                           busy;
    logic                           reject;
    logic                           game_over;
    logic [1:0]                     winner;

    modport master (
        output column, load, first_player,
        input  board, cur_player, secs, busy, reject, game_over, winner
    );

    modport slave (
        input  column, load, first_player,
        output board, cur_player, secs, busy, reject, game_over, winner
    );
endinterface

// File: rtl/turn_timer.sv
// Per-turn seconds counter; counts only while run is high and pulses time_out at the limit.
module turn_timer #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned TURN_SECS = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           run,
    output logic [$clog2(TURN_SECS+1)-1:0] secs,
    output logic                           time_out
);
    localparam int unsigned CNTW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned SW   = $clog2(TURN_SECS + 1);

    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [SW-1:0]   secs_q, secs_d;

    assign time_out = run && (32'(secs_q) == TURN_SECS);
    assign secs     = secs_q;

    always_comb begin
        cnt_d  = cnt_q;
        secs_d = secs_q;
        if (clear || !run || time_out) begin
            cnt_d  = '0;
            secs_d = '0;
        end else if (32'(cnt_q) == CLK_HZ - 1) begin
            cnt_d  = '0;
            secs_d = secs_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            secs_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            secs_q <= secs_d;
        end
    end
endmodule

// File: rtl/connect4_board_ctrl.sv
// Connect-4 game core: column drop, one-direction-per-cycle win scan, draw and turn timeout.
module connect4_board_ctrl
    import connect4_pkg::*;
#(
    parameter int unsigned ROWS      = 6,
    parameter int unsigned COLS      = 7,
    parameter int unsigned WIN_LEN   = 4,
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned TURN_SECS = 10
) (
    input logic                 clk,
    input logic                 rst,
    connect4_board_ctrl_if.slave bus
);
    localparam int unsigned CW   = $clog2(COLS);
    localparam int unsigned RW   = $clog2(ROWS);
    localparam int unsigned HW   = $clog2(ROWS + 1);
    localparam int unsigned NW   = $clog2(ROWS * COLS + 1);
    localparam int unsigned MAXD = (ROWS > COLS) ? ROWS : COLS;
    localparam int unsigned IW   = $clog2(MAXD) + 2;

    localparam logic signed [IW-1:0] ROWS_S = IW'(ROWS);
    localparam logic signed [IW-1:0] COLS_S = IW'(COLS);
    localparam logic signed [IW-1:0] PLUS   = IW'(1);
    localparam logic signed [IW-1:0] MINUS  = '1;

    state_t          state_q, state_d;
    cell_t           board_q [ROWS][COLS];
    cell_t           board_d [ROWS][COLS];
    logic [HW-1:0]   height_q [COLS];
    logic [HW-1:0]   height_d [COLS];
    logic [NW-1:0]   count_q, count_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic            cur_player_q, cur_player_d;
    logic            reject_q, reject_d;
    logic            game_over_q, game_over_d;
    logic [1:0]      winner_q, winner_d;

    cell_t           cur_code;
    logic            time_out;
    logic            col_ok, col_full;
    logic [CW-1:0]   col_idx;
    logic            win;
    logic [2*ROWS*COLS-1:0] board_flat;
    logic [$clog2(TURN_SECS+1)-1:0] secs;

    assign cur_code = player_code(cur_player_q);

    turn_timer #(
        .CLK_HZ   (CLK_HZ),
        .TURN_SECS(TURN_SECS)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == StSwap),
        .run     (state_q == StWait),
        .secs    (secs),
        .time_out(time_out)
    );

    // Run length through (row_q, col_q) along the direction selected by the current check state.
    always_comb begin
        logic signed [IW-1:0] dr, dc, rr, cc;
        logic                 go;
        int unsigned          run_len;
        dr = '0;
        dc = PLUS;
        unique case (state_q)
            StChkV:  begin dr = PLUS; dc = '0;    end
            StChkD1: begin dr = PLUS; dc = PLUS;  end
            StChkD2: begin dr = PLUS; dc = MINUS; end
            default: begin dr = '0;   dc = PLUS;  end
        endcase
        run_len = 1;
        for (int s = 0; s < 2; s++) begin
            go = 1'b1;
            rr = IW'(row_q);
            cc = IW'(col_q);
            for (int unsigned k = 1; k < WIN_LEN; k++) begin
                if (s == 0) begin
                    rr = rr + dr;
                    cc = cc + dc;
                end else begin
                    rr = rr - dr;
                    cc = cc - dc;
                end
                if (go && !rr[IW-1] && rr < ROWS_S && !cc[IW-1] && cc < COLS_S) begin
                    if (board_q[rr[RW-1:0]][cc[CW-1:0]] == cur_code) run_len = run_len + 1;
                    else go = 1'b0;
                end else begin
                    go = 1'b0;
                end
            end
        end
        win = (run_len >= WIN_LEN);
    end

    assign col_ok   = 32'(bus.column) < COLS;
    assign col_idx  = col_ok ? bus.column : '0;
    assign col_full = 32'(height_q[col_idx]) >= ROWS;

    always_comb begin
        state_d      = state_q;
        board_d      = board_q;
        height_d     = height_q;
        count_d      = count_q;
        row_d        = row_q;
        col_d        = col_q;
        cur_player_d = cur_player_q;
        reject_d     = 1'b0;
        game_over_d  = game_over_q;
        winner_d     = winner_q;
        unique case (state_q)
            StWait: begin
                // Timeout outranks a simultaneous load, which is then dropped silently.
                if (time_out) begin
                    cur_player_d = ~cur_player_q;
                end else if (bus.load) begin
                    if (col_ok && !col_full) begin
                        row_d   = height_q[col_idx][RW-1:0];
                        col_d   = col_idx;
                        state_d = StDrop;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            StDrop: begin
                board_d[row_q][col_q] = cur_code;
                height_d[col_q]       = height_q[col_q] + 1'b1;
                count_d               = count_q + 1'b1;
                state_d               = StChkH;
            end
            StChkH, StChkV, StChkD1, StChkD2: begin
                if (win) begin
                    winner_d    = cur_code;
                    game_over_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    unique case (state_q)
                        StChkH:  state_d = StChkV;
                        StChkV:  state_d = StChkD1;
                        StChkD1: state_d = StChkD2;
                        default: state_d = StSwap;
                    endcase
                end
            end
            StSwap: begin
                if (32'(count_q) == ROWS * COLS) begin
                    winner_d    = WIN_DRAW;
                    game_over_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    cur_player_d = ~cur_player_q;
                    state_d      = StWait;
                end
            end
            StDone: state_d = StDone;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StWait;
            board_q      <= '{default: EMPTY};
            height_q     <= '{default: '0};
            count_q      <= '0;
            row_q        <= '0;
            col_q        <= '0;
            cur_player_q <= bus.first_player;
            reject_q     <= 1'b0;
            game_over_q  <= 1'b0;
            winner_q     <= '0;
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            height_q     <= height_d;
            count_q      <= count_d;
            row_q        <= row_d;
            col_q        <= col_d;
            cur_player_q <= cur_player_d;
            reject_q     <= reject_d;
            game_over_q  <= game_over_d;
            winner_q     <= winner_d;
        end
    end

    always_comb begin
        board_flat = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                board_flat[2*(r*COLS+c) +: 2] = board_q[r][c];
            end
        end
    end

    assign bus.board      = board_flat;
    assign bus.cur_player = cur_player_q;
    assign bus.secs       = secs;
    assign bus.busy       = (state_q != StWait) && (state_q != StDone);
    assign bus.reject     = reject_q;
    assign bus.game_over  = game_over_q;
    assign bus.winner     = winner_q;
endmodule

// File: tb/tb_connect4_board_ctrl.sv
// Directed bench for the Connect-4 core: a 6x7 instance for play/timeout and a 2x2 one for draw.
module tb_connect4_board_ctrl;
    logic clk;
    logic rst_a;
    logic rst_b;
    int   vectors;
    int   miscompares;

    connect4_board_ctrl_if #(.ROWS(6), .COLS(7), .TURN_SECS(3)) bus_a ();
    connect4_board_ctrl_if #(.ROWS(2), .COLS(2), .TURN_SECS(3)) bus_b ();

    connect4_board_ctrl #(
        .ROWS(6), .COLS(7), .WIN_LEN(4), .CLK_HZ(4), .TURN_SECS(3)
    ) dut_a (
        .clk(clk),
        .rst(rst_a),
        .bus(bus_a)
    );

    connect4_board_ctrl #(
        .ROWS(2), .COLS(2), .WIN_LEN(3), .CLK_HZ(4), .TURN_SECS(3)
    ) dut_b (
        .clk(clk),
        .rst(rst_b),
        .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic move_a(input logic [2:0] col);
        bus_a.column = col;
        bus_a.load   = 1'b1;
        @(negedge clk);
        bus_a.load = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic move_b(input logic col);
        bus_b.column = col;
        bus_b.load   = 1'b1;
        @(negedge clk);
        bus_b.load = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        vectors            = 0;
        miscompares        = 0;
        bus_a.column       = '0;
        bus_a.load         = 1'b0;
        bus_a.first_player = 1'b1;
        bus_b.column       = '0;
        bus_b.load         = 1'b0;
        bus_b.first_player = 1'b0;
        rst_a              = 1'b1;
        rst_b              = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;

        // Reset state
        check("rst_board", bus_a.board, '0);
        check("rst_cur", bus_a.cur_player, 1'b1);
        check("rst_winner", bus_a.winner, 2'b00);
        check("rst_busy", bus_a.busy, 1'b0);
        check("rst_secs", bus_a.secs, 2'd0);
        check("rst_over", bus_a.game_over, 1'b0);

        // First drop and exact six-cycle flip latency
        bus_a.column = 3'd3;
        bus_a.load   = 1'b1;
        @(negedge clk);
        bus_a.load = 1'b0;
        check("drop_busy", bus_a.busy, 1'b1);
        repeat (5) @(negedge clk);
        check("pre_flip_cur", bus_a.cur_player, 1'b1);
        @(negedge clk);
        check("flip_cur", bus_a.cur_player, 1'b0);
        check("drop1_board", bus_a.board, 84'h80);
        check("drop1_busy", bus_a.busy, 1'b0);
        move_a(3'd3);
        check("stack_board", bus_a.board, 84'h100080);
        check("stack_cur", bus_a.cur_player, 1'b1);

        // Fill column 0, then full column and out-of-range column are rejected
        repeat (6) move_a(3'd0);
        check("fill_board", bus_a.board, 84'h000400200040020104082);
        check("fill_cur", bus_a.cur_player, 1'b1);
        bus_a.column = 3'd0;
        bus_a.load   = 1'b1;
        @(negedge clk);
        bus_a.load = 1'b0;
        check("full_reject", bus_a.reject, 1'b1);
        check("full_busy", bus_a.busy, 1'b0);
        @(negedge clk);
        check("full_reject_end", bus_a.reject, 1'b0);
        check("full_board", bus_a.board, 84'h000400200040020104082);
        bus_a.column = 3'd7;
        bus_a.load   = 1'b1;
        @(negedge clk);
        bus_a.load = 1'b0;
        check("col7_reject", bus_a.reject, 1'b1);
        @(negedge clk);
        check("col7_reject_end", bus_a.reject, 1'b0);
        check("col7_cur", bus_a.cur_player, 1'b1);

        // Horizontal win for player 0 on the bottom row
        bus_a.first_player = 1'b0;
        rst_a = 1'b1;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        move_a(3'd0);
        move_a(3'd6);
        move_a(3'd1);
        move_a(3'd6);
        move_a(3'd2);
        move_a(3'd6);
        check("pre_win_over", bus_a.game_over, 1'b0);
        move_a(3'd3);
        check("win_winner", bus_a.winner, 2'b01);
        check("win_over", bus_a.game_over, 1'b1);
        check("win_busy", bus_a.busy, 1'b0);
        check("win_cur", bus_a.cur_player, 1'b0);
        check("win_board", bus_a.board, 84'h200_0800_2055);
        bus_a.column = 3'd4;
        bus_a.load   = 1'b1;
        @(negedge clk);
        bus_a.load = 1'b0;
        check("done_reject", bus_a.reject, 1'b0);
        check("done_busy", bus_a.busy, 1'b0);
        repeat (5) @(negedge clk);
        check("done_board", bus_a.board, 84'h200_0800_2055);
        check("done_secs", bus_a.secs, 2'd0);
        check("done_winner", bus_a.winner, 2'b01);

        // Turn timeout, and a load coinciding with timeout is dropped
        bus_a.first_player = 1'b0;
        rst_a = 1'b1;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        repeat (4) @(negedge clk);
        check("secs_1", bus_a.secs, 2'd1);
        repeat (4) @(negedge clk);
        check("secs_2", bus_a.secs, 2'd2);
        repeat (4) @(negedge clk);
        check("secs_3", bus_a.secs, 2'd3);
        check("secs_3_cur", bus_a.cur_player, 1'b0);
        @(negedge clk);
        check("tmo_secs", bus_a.secs, 2'd0);
        check("tmo_cur", bus_a.cur_player, 1'b1);
        check("tmo_board", bus_a.board, '0);
        repeat (12) @(negedge clk);
        check("secs_3_again", bus_a.secs, 2'd3);
        bus_a.column = 3'd2;
        bus_a.load   = 1'b1;
        @(negedge clk);
        bus_a.load = 1'b0;
        check("tmo_load_cur", bus_a.cur_player, 1'b0);
        check("tmo_load_busy", bus_a.busy, 1'b0);
        check("tmo_load_reject", bus_a.reject, 1'b0);
        check("tmo_load_secs", bus_a.secs, 2'd0);
        repeat (6) @(negedge clk);
        check("tmo_load_board", bus_a.board, '0);

        // 2x2 board: full without a line is a draw
        rst_b = 1'b0;
        move_b(1'b0);
        move_b(1'b1);
        move_b(1'b0);
        check("b_pre_draw_over", bus_b.game_over, 1'b0);
        move_b(1'b1);
        check("draw_winner", bus_b.winner, 2'b11);
        check("draw_over", bus_b.game_over, 1'b1);
        check("draw_board", bus_b.board, 8'h99);
        check("draw_cur", bus_b.cur_player, 1'b1);
        check("draw_busy", bus_b.busy, 1'b0);

        // Reset in the middle of a move restores everything
        bus_b.first_player = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        bus_b.column = 1'b0;
        bus_b.load   = 1'b1;
        @(negedge clk);
        bus_b.load = 1'b0;
        @(negedge clk);
        check("mid_busy", bus_b.busy, 1'b1);
        check("mid_board", bus_b.board, 8'h02);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        check("mrst_board", bus_b.board, 8'h00);
        check("mrst_busy", bus_b.busy, 1'b0);
        check("mrst_cur", bus_b.cur_player, 1'b1);
        check("mrst_winner", bus_b.winner, 2'b00);
        check("mrst_over", bus_b.game_over, 1'b0);
        check("mrst_secs", bus_b.secs, 2'd0);
        move_b(1'b0);
        check("mrst_move_board", bus_b.board, 8'h02);
        check("mrst_move_cur", bus_b.cur_player, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
